ram_responder: RTL and testbench

Memory-side responder for the CPU's MFA/MOC memory handshake. It owns the byte-addressed, big-endian RAM that the control unit fetches instructions from and that load/store instructions access. It serves byte, halfword and word reads and writes with a configurable number of wait states and signals misaligned accesses. The array is named `Mem` and is byte-wide, so benches can preload it by hierarchical reference before releasing reset.

---
 rtl/ram_responder_pkg.sv | 36 +++
 rtl/ram_responder_if.sv | 23 ++
 rtl/ram_responder_array.sv | 40 ++++
 rtl/ram_responder.sv | 124 ++++++++++++
 tb/tb_ram_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// Shared definitions for the MFA/MOC memory responder: access-size codes,
// FSM states and the alignment rule used to reject illegal accesses.
package mem_pkg;

    typedef enum logic [1:0] {
        DT_BYTE = 2'b00,
        DT_HALF = 2'b01,
        DT_WORD = 2'b10,
        DT_RSVD = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Reserved size is never aligned, so it always ends up as an error.
    function automatic logic isAligned(input dtype_e dt, input logic [1:0] lsb);
        case (dt)
            DT_BYTE: return 1'b1;
            DT_HALF: return ~lsb[0];
            DT_WORD: return (lsb == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] accessBytes(input dtype_e dt);
        case (dt)
            DT_HALF: return 3'd2;
            DT_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// CPU-to-memory request/response bundle of the MFA/MOC four-phase handshake.
interface ram_responder_if #(
    parameter int ADDR_W = 8
);
    logic              mfa;
    logic              rw;
    logic [1:0]        dtype;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              moc;
    logic              err;

    modport master (
        output mfa, rw, dtype, addr, din,
        input  dout, moc, err
    );

    modport slave (
        input  mfa, rw, dtype, addr, din,
        output dout, moc, err
    );
endinterface

// File: rtl/ram_responder_array.sv
// Byte-wide storage with a 4-lane big-endian port; lane k addresses base+k and
// maps to data bits [31-8k -: 8]. Lanes falling past DEPTH are ignored.
module ram_byte_array #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int IW  = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int AW1 = ADDR_W + 1;

    logic [7:0]     Mem [DEPTH];
    logic [AW1-1:0] laneAddr [4];
    logic [3:0]     inRange;

    always_comb begin
        rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            laneAddr[k] = {1'b0, addr} + AW1'(k);
            inRange[k]  = (laneAddr[k] < AW1'(DEPTH));
            if (inRange[k]) begin
                rdata[8*(3-k) +: 8] = Mem[laneAddr[k][IW-1:0]];
            end
        end
    end

    // Contents are deliberately left out of reset so a bench can preload them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k] && inRange[k]) begin
                Mem[laneAddr[k][IW-1:0]] <= wdata[8*(3-k) +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side MFA/MOC responder: captures a request, waits WAIT_STATES cycles,
// commits a big-endian byte/half/word access and holds the result until MFA drops.
module ram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           clr,
    ram_responder_if.slave bus
);
    localparam int CW  = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int AW1 = ADDR_W + 1;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    dtype_e            dtype_q;
    logic [31:0]       din_q;
    logic [31:0]       dout_q;
    logic              moc_q;
    logic              err_q;

    logic              commit;
    logic              accessOk;
    logic [AW1-1:0]    lastByte;
    logic [3:0]        laneMask;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       readValue;

    // The capture edge is always followed by the WAIT count, so completion
    // lands WAIT_STATES+1 edges after capture even when WAIT_STATES is zero.
    assign commit   = (state_q == ST_WAIT) && (cnt_q == CW'(WAIT_STATES));
    assign lastByte = {1'b0, addr_q} + AW1'(accessBytes(dtype_q)) - AW1'(1);
    assign accessOk = isAligned(dtype_q, addr_q[1:0]) && (lastByte < AW1'(DEPTH));
    assign we       = (commit && !rw_q && accessOk) ? laneMask : 4'b0000;

    always_comb begin
        laneMask  = 4'b0001;
        wdata     = {din_q[7:0], 24'h0};
        readValue = {24'h0, rdata[31:24]};
        case (dtype_q)
            DT_HALF: begin
                laneMask  = 4'b0011;
                wdata     = {din_q[15:0], 16'h0};
                readValue = {16'h0, rdata[31:16]};
            end
            DT_WORD: begin
                laneMask  = 4'b1111;
                wdata     = din_q;
                readValue = rdata;
            end
            default: ;
        endcase
    end

    ram_byte_array #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) ram (
        .clk  (clk),
        .we   (we),
        .addr (addr_q),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            dtype_q <= DT_BYTE;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mfa) begin
                        addr_q  <= bus.addr;
                        rw_q    <= bus.rw;
                        dtype_q <= dtype_e'(bus.dtype);
                        din_q   <= bus.din;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        moc_q   <= 1'b1;
                        err_q   <= !accessOk;
                        state_q <= ST_DONE;
                        if (rw_q && accessOk) begin
                            dout_q <= readValue;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.mfa) begin
                        moc_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.moc  = moc_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: three instances (2 wait states/256 B,
// 0 wait states/16 B, 3 wait states/256 B) against a byte-array reference model.
module tb_ram_responder;

    logic        clk;
    logic        clrV  [3];
    logic        mfaV  [3];
    logic        mocV  [3];
    logic        errV  [3];
    logic [31:0] doutV [3];
    logic        rwS;
    logic [1:0]  dtypeS;
    logic [7:0]  addrS;
    logic [31:0] dinS;

    int          checks;
    int          errors;

    logic [7:0]  model    [3][256];
    logic [31:0] lastDout [3];
    int          depthOf  [3] = '{256, 16, 256};
    int          wsOf     [3] = '{2, 0, 3};

    ram_responder_if #(.ADDR_W(8)) bus0 ();
    ram_responder_if #(.ADDR_W(8)) bus1 ();
    ram_responder_if #(.ADDR_W(8)) bus2 ();

    assign bus0.mfa = mfaV[0];
    assign bus1.mfa = mfaV[1];
    assign bus2.mfa = mfaV[2];
    assign bus0.rw = rwS;       assign bus1.rw = rwS;       assign bus2.rw = rwS;
    assign bus0.dtype = dtypeS; assign bus1.dtype = dtypeS; assign bus2.dtype = dtypeS;
    assign bus0.addr = addrS;   assign bus1.addr = addrS;   assign bus2.addr = addrS;
    assign bus0.din = dinS;     assign bus1.din = dinS;     assign bus2.din = dinS;
    assign mocV[0] = bus0.moc;  assign errV[0] = bus0.err;  assign doutV[0] = bus0.dout;
    assign mocV[1] = bus1.moc;  assign errV[1] = bus1.err;  assign doutV[1] = bus1.dout;
    assign mocV[2] = bus2.moc;  assign errV[2] = bus2.err;  assign doutV[2] = bus2.dout;

    ram_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(2)) dut0 (
        .clk(clk), .clr(clrV[0]), .bus(bus0)
    );
    ram_responder #(.ADDR_W(8), .DEPTH(16), .WAIT_STATES(0)) dut1 (
        .clk(clk), .clr(clrV[1]), .bus(bus1)
    );
    ram_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) dut2 (
        .clk(clk), .clr(clrV[2]), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic backdoorWrite(input int d, input int i, input logic [7:0] v);
        case (d)
            0: dut0.ram.Mem[i] = v;
            1: dut1.ram.Mem[i] = v;
            default: dut2.ram.Mem[i] = v;
        endcase
        model[d][i] = v;
    endtask

    function automatic logic [7:0] backdoorRead(input int d, input int i);
        case (d)
            0: return dut0.ram.Mem[i];
            1: return dut1.ram.Mem[i];
            default: return dut2.ram.Mem[i];
        endcase
    endfunction

    // Reference: size from the code, error if misaligned/reserved/past the end.
    task automatic modelAccess(input int d, input logic rd, input logic [1:0] dt,
                               input logic [7:0] a, input logic [31:0] data,
                               output logic expErr, output logic [31:0] expDout);
        int n;
        int ai;
        ai = int'(a);
        case (dt)
            2'b00: n = 1;
            2'b01: n = 2;
            2'b10: n = 4;
            default: n = 0;
        endcase
        if (n == 0) expErr = 1'b1;
        else expErr = ((ai % n) != 0) || (ai + n > depthOf[d]);
        if (!expErr && rd) begin
            lastDout[d] = 32'h0;
            for (int i = 0; i < n; i++) lastDout[d] = (lastDout[d] << 8) | 32'(model[d][ai + i]);
        end else if (!expErr) begin
            for (int i = 0; i < n; i++) model[d][ai + i] = data[8*(n-1-i) +: 8];
        end
        expDout = lastDout[d];
    endtask

    // Runs one handshake starting at a negedge; scrambles the request lines
    // while the access is pending and reports what the responder produced.
    task automatic doAccess(input int d, input logic rd, input logic [1:0] dt,
                            input logic [7:0] a, input logic [31:0] data, input int holdCycles,
                            output int lat, output logic gotErr, output logic [31:0] gotDout,
                            output logic holdOk, output logic relMoc);
        bit seen;
        int i;
        seen   = 0;
        lat    = -1;
        holdOk = 1'b1;
        rwS = rd; dtypeS = dt; addrS = a; dinS = data;
        mfaV[d] = 1'b1;
        i = 0;
        while (!seen && i < 40) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                rwS = 1'($urandom); dtypeS = 2'($urandom);
                addrS = 8'($urandom); dinS = $urandom;
            end
            if (mocV[d] === 1'b1) begin
                seen = 1;
                lat  = i - 1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout dut%0d: moc got %b required 1 within 40 cycles", d, mocV[d]);
        end
        gotErr  = errV[d];
        gotDout = doutV[d];
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            if (mocV[d] !== 1'b1 || errV[d] !== gotErr || doutV[d] !== gotDout) holdOk = 1'b0;
        end
        mfaV[d] = 1'b0;
        @(negedge clk);
        relMoc = mocV[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (mocV[d] !== 1'b0 || errV[d] !== 1'b0 || doutV[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_in dut%0d: moc/err/dout got %b/%b/%h required 0/0/00000000",
                         d, mocV[d], errV[d], doutV[d]);
            end
        end
        for (int d = 0; d < 3; d++) clrV[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (mocV[d] !== 1'b0 || errV[d] !== 1'b0 || doutV[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_out dut%0d: moc/err/dout got %b/%b/%h required 0/0/00000000",
                         d, mocV[d], errV[d], doutV[d]);
            end
        end
    endtask

    task automatic test_word_read();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        modelAccess(0, 1'b1, 2'b10, 8'd0, 32'h0, ee, eq);
        doAccess(0, 1'b1, 2'b10, 8'd0, 32'h0, 0, lat, e, q, hok, rel);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL word_read latency: got %0d required 3", lat); end
        checks++;
        if (q !== 32'hE3A01004 || e !== 1'b0) begin
            errors++; $display("[TB] FAIL word_read data: got %h err %b required E3A01004 err 0", q, e);
        end
        checks++;
        if (q !== eq) begin errors++; $display("[TB] FAIL word_read model: got %h required %h", q, eq); end
        checks++;
        if (rel !== 1'b0) begin errors++; $display("[TB] FAIL word_read release: moc got %b required 0", rel); end
    endtask

    task automatic test_mixed_size();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        logic [1:0]  dts [5] = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b00};
        logic [7:0]  ads [5] = '{8'd8, 8'd9, 8'd8, 8'd10, 8'd11};
        logic        rds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] dins[5] = '{32'h11223344, 32'hFFFFFFAA, 32'h0, 32'h0, 32'h0};
        logic [31:0] reqs[5] = '{32'h0, 32'h0, 32'h11AA3344, 32'h00003344, 32'h00000044};
        for (int t = 0; t < 5; t++) begin
            modelAccess(0, rds[t], dts[t], ads[t], dins[t], ee, eq);
            doAccess(0, rds[t], dts[t], ads[t], dins[t], 0, lat, e, q, hok, rel);
            checks++;
            if (e !== 1'b0) begin errors++; $display("[TB] FAIL mixed_err step%0d: got %b required 0", t, e); end
            if (rds[t]) begin
                checks++;
                if (q !== reqs[t]) begin
                    errors++; $display("[TB] FAIL mixed_read step%0d: got %h required %h", t, q, reqs[t]);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        int bad;
        logic [1:0] dts [3] = '{2'b10, 2'b01, 2'b11};
        logic [7:0] ads [3] = '{8'd2, 8'd5, 8'd0};
        logic       rds [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            modelAccess(0, rds[t], dts[t], ads[t], 32'hDEADBEEF, ee, eq);
            doAccess(0, rds[t], dts[t], ads[t], 32'hDEADBEEF, 0, lat, e, q, hok, rel);
            checks++;
            if (lat !== 3 || e !== 1'b1 || ee !== 1'b1) begin
                errors++; $display("[TB] FAIL misalign_err case%0d: lat %0d err %b required 3 and 1", t, lat, e);
            end
            checks++;
            if (q !== 32'h00000044) begin
                errors++; $display("[TB] FAIL misalign_dout case%0d: got %h required 00000044", t, q);
            end
        end
        bad = 0;
        for (int i = 0; i < 12; i++) if (backdoorRead(0, i) !== model[0][i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL misalign_mem: %0d bytes differ required 0", bad); end
    endtask

    task automatic test_zero_wait();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        logic [1:0] dts [6] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        logic [7:0] ads [6] = '{8'd0, 8'd12, 8'd16, 8'd15, 8'd16, 8'd14};
        logic       rds [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       errs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 6; t++) begin
            modelAccess(1, rds[t], dts[t], ads[t], 32'h5555AAAA, ee, eq);
            doAccess(1, rds[t], dts[t], ads[t], 32'h5555AAAA, 0, lat, e, q, hok, rel);
            checks++;
            if (lat !== 1) begin errors++; $display("[TB] FAIL zw_latency case%0d: got %0d required 1", t, lat); end
            checks++;
            if (e !== errs[t] || q !== eq) begin
                errors++;
                $display("[TB] FAIL zw_result case%0d: err %b dout %h required err %b dout %h", t, e, q, errs[t], eq);
            end
        end
    endtask

    task automatic test_reset_wait();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        int bad;
        modelAccess(2, 1'b1, 2'b10, 8'd0, 32'h0, ee, eq);
        doAccess(2, 1'b1, 2'b10, 8'd0, 32'h0, 0, lat, e, q, hok, rel);
        checks++;
        if (q !== eq || lat !== 4) begin
            errors++; $display("[TB] FAIL rw_preread: dout %h lat %0d required %h lat 4", q, lat, eq);
        end
        rwS = 1'b0; dtypeS = 2'b10; addrS = 8'd4; dinS = 32'hFFFFFFFF;
        mfaV[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clrV[2] = 1'b0;
        #1;
        checks++;
        if (mocV[2] !== 1'b0 || doutV[2] !== 32'h0 || errV[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rw_abort: moc/err/dout got %b/%b/%h required 0/0/00000000", mocV[2], errV[2], doutV[2]);
        end
        lastDout[2] = 32'h0;
        mfaV[2] = 1'b0;
        @(negedge clk);
        clrV[2] = 1'b1;
        bad = 0;
        for (int i = 4; i < 8; i++) if (backdoorRead(2, i) !== model[2][i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL rw_mem: %0d bytes written required 0", bad); end
        modelAccess(2, 1'b1, 2'b10, 8'd4, 32'h0, ee, eq);
        doAccess(2, 1'b1, 2'b10, 8'd4, 32'h0, 0, lat, e, q, hok, rel);
        checks++;
        if (q !== 32'h5A5B5C5D || q !== eq || e !== 1'b0 || lat !== 4) begin
            errors++; $display("[TB] FAIL rw_next: dout %h err %b lat %0d required 5A5B5C5D 0 4", q, e, lat);
        end
    endtask

    task automatic test_held();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        logic [7:0] a, v;
        a = 8'($urandom_range(16, 250));
        v = 8'($urandom);
        modelAccess(0, 1'b0, 2'b00, a, {24'hABCDEF, v}, ee, eq);
        doAccess(0, 1'b0, 2'b00, a, {24'hABCDEF, v}, 10, lat, e, q, hok, rel);
        checks++;
        if (hok !== 1'b1 || e !== 1'b0) begin
            errors++; $display("[TB] FAIL held_moc: hold ok %b err %b required 1 and 0", hok, e);
        end
        checks++;
        if (rel !== 1'b0) begin errors++; $display("[TB] FAIL held_release: moc got %b required 0", rel); end
        modelAccess(0, 1'b1, 2'b00, a, 32'h0, ee, eq);
        doAccess(0, 1'b1, 2'b00, a, 32'h0, 0, lat, e, q, hok, rel);
        checks++;
        if (q !== {24'h0, v} || q !== eq) begin
            errors++; $display("[TB] FAIL held_readback: got %h required %h", q, {24'h0, v});
        end
    endtask

    task automatic test_random();
        int lat; logic e, ee, hok, rel; logic [31:0] q, eq;
        int d; logic rd; logic [1:0] dt; logic [7:0] a; logic [31:0] w;
        for (int t = 0; t < 60; t++) begin
            d  = (t < 40) ? 0 : 1;
            rd = 1'($urandom);
            dt = 2'($urandom);
            a  = (d == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
            w  = $urandom;
            modelAccess(d, rd, dt, a, w, ee, eq);
            doAccess(d, rd, dt, a, w, 0, lat, e, q, hok, rel);
            checks++;
            if (lat !== wsOf[d] + 1) begin
                errors++; $display("[TB] FAIL rand_lat t%0d: got %0d required %0d", t, lat, wsOf[d] + 1);
            end
            checks++;
            if (e !== ee) begin
                errors++; $display("[TB] FAIL rand_err t%0d dt %b a %0d: got %b required %b", t, dt, a, e, ee);
            end
            checks++;
            if (q !== eq) begin
                errors++; $display("[TB] FAIL rand_dout t%0d dt %b a %0d: got %h required %h", t, dt, a, q, eq);
            end
        end
        for (int i = 0; i < 256; i++) begin
            if (backdoorRead(0, i) !== model[0][i]) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_mem byte %0d: got %h required %h", i, backdoorRead(0, i), model[0][i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rwS = 1'b1; dtypeS = 2'b00; addrS = 8'd0; dinS = 32'h0;
        for (int d = 0; d < 3; d++) begin
            clrV[d] = 1'b0;
            mfaV[d] = 1'b0;
            lastDout[d] = 32'h0;
        end
        #2;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) model[d][i] = 8'h00;
            for (int i = 0; i < depthOf[d]; i++) backdoorWrite(d, i, 8'($urandom));
        end
        backdoorWrite(0, 0, 8'hE3); backdoorWrite(0, 1, 8'hA0);
        backdoorWrite(0, 2, 8'h10); backdoorWrite(0, 3, 8'h04);
        backdoorWrite(2, 4, 8'h5A); backdoorWrite(2, 5, 8'h5B);
        backdoorWrite(2, 6, 8'h5C); backdoorWrite(2, 7, 8'h5D);
        repeat (3) @(negedge clk);

        $display("[TB] starting ram_responder bench");
        test_reset();
        test_word_read();
        test_mixed_size();
        test_misaligned();
        test_zero_wait();
        test_reset_wait();
        test_held();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
